// File: rtl/perceptron_sig_core_pkg.sv
// Shared fp32 field layout and the fixed constants used by the sigmoid approximation.
package perceptron_sig_core_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] ONE      = 32'h3F80_0000;
  localparam logic [31:0] HALF     = 32'h3F00_0000;
  localparam logic [31:0] T5       = 32'h40A0_0000;
  localparam logic [31:0] T2375    = 32'h4018_0000;
  localparam logic [31:0] C0_84375 = 32'h3F58_0000;
  localparam logic [31:0] C0_625   = 32'h3F20_0000;

endpackage

// File: rtl/perceptron_sig_core_fp32_add.sv
// Combinational fp32 adder: align, add/sub, normalize, truncate (round toward zero).
// Denormals read as zero, exp=255 reads as infinity, overflow saturates, underflow flushes.
module fp32_add
  import perceptron_sig_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  fp32_t fa, fb, hi, lo;
  logic [7:0]        d;
  logic [26:0]       mb, ms, msa, lost;
  logic [27:0]       sum, norm;
  logic [4:0]        msb;
  logic signed [9:0] e;
  logic              unused_bits;

  assign fa = a;
  assign fb = b;

  always_comb begin
    hi   = fa;
    lo   = fb;
    d    = '0;
    mb   = '0;
    ms   = '0;
    msa  = '0;
    lost = '0;
    sum  = '0;
    norm = '0;
    msb  = '0;
    e    = '0;
    y    = '0;
    if (fa.exp == 8'hff || fb.exp == 8'hff) begin
      y = (fa.exp == 8'hff) ? {fa.sign, 8'hff, 23'd0} : {fb.sign, 8'hff, 23'd0};
    end else if (fa.exp == 8'd0) begin
      y = (fb.exp == 8'd0) ? 32'd0 : fb;
    end else if (fb.exp == 8'd0) begin
      y = fa;
    end else begin
      if ({fb.exp, fb.mant} > {fa.exp, fa.mant}) begin
        hi = fb;
        lo = fa;
      end
      d  = hi.exp - lo.exp;
      mb = {1'b1, hi.mant, 3'b000};
      ms = {1'b1, lo.mant, 3'b000};
      // Bits shifted out collapse into a sticky LSB so subtraction still truncates correctly.
      if (d >= 8'd27) begin
        msa = 27'd1;
      end else begin
        msa    = ms >> d;
        lost   = ms << (8'd27 - d);
        msa[0] = msa[0] | (|lost);
      end
      sum = (hi.sign == lo.sign) ? ({1'b0, mb} + {1'b0, msa}) : ({1'b0, mb} - {1'b0, msa});
      for (int i = 0; i < 28; i++) begin
        if (sum[i]) msb = 5'(i);
      end
      norm = sum << (5'd27 - msb);
      e    = $signed({2'b00, hi.exp}) + $signed({5'b00000, msb}) - 10'sd26;
      if (sum == 28'd0)        y = 32'd0;
      else if (e >= 10'sd255)  y = {hi.sign, 8'hff, 23'd0};
      else if (e <= 10'sd0)    y = {hi.sign, 31'd0};
      else                     y = {hi.sign, e[7:0], norm[26:4]};
    end
  end

  assign unused_bits = ^{norm[27], norm[3:0], e[9:8]};

endmodule

// File: rtl/perceptron_sig_core.sv
// Single neuron: walks COUNTER_END w*x pairs, adds bias, applies sigmoid or ReLU/identity
// (PERCEPTRON_RELU_EN); result registered one cycle after the frame sum; no backpressure.
module perceptron_sig_core
  import perceptron_sig_core_pkg::*;
#(
  parameter int unsigned COUNTER_END = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        activation_function,
  input  logic [31:0] b,
  input  logic [31:0] w,
  input  logic [31:0] x,
  output logic [31:0] counter,
  output logic [31:0] data_out,
  output logic        out_valid
);

  localparam logic [31:0] LAST = 32'(COUNTER_END - 1);

  fp32_t             fw, fx, fz;
  logic [31:0]       prod, acc, acc_next, sum_r, z;
  logic [31:0]       t_bits, scaled, offs, y_lin, y_pos, y_neg, sig, lin, act_val;
  logic [7:0]        k;
  logic [47:0]       p;
  logic signed [9:0] pe;
  logic              psign, sum_vld, unused_mul;

  assign fw    = w;
  assign fx    = x;
  assign psign = fw.sign ^ fx.sign;

  always_comb begin
    p    = {1'b1, fw.mant} * {1'b1, fx.mant};
    pe   = $signed({2'b00, fw.exp}) + $signed({2'b00, fx.exp}) - 10'sd127
         + $signed({9'd0, p[47]});
    prod = '0;
    if (fw.exp == 8'hff || fx.exp == 8'hff) prod = {psign, 8'hff, 23'd0};
    else if (fw.exp == 8'd0 || fx.exp == 8'd0) prod = '0;
    else if (pe >= 10'sd255) prod = {psign, 8'hff, 23'd0};
    else if (pe <= 10'sd0)   prod = {psign, 31'd0};
    else prod = {psign, pe[7:0], (p[47] ? p[46:24] : p[45:23])};
  end

  assign unused_mul = ^{p[22:0], pe[9:8]};

  fp32_add u_acc  (.a(acc),   .b(prod), .y(acc_next));
  fp32_add u_bias (.a(sum_r), .b(b),    .y(z));

  assign fz     = z;
  assign t_bits = {1'b0, z[30:0]};

  // Slope multiply is an exponent decrement; too-small results flush to zero.
  always_comb begin
    k    = 8'd2;
    offs = HALF;
    if (t_bits >= T2375) begin
      k    = 8'd5;
      offs = C0_84375;
    end else if (t_bits >= ONE) begin
      k    = 8'd3;
      offs = C0_625;
    end
    scaled = '0;
    if (fz.exp > k) scaled = {1'b0, fz.exp - k, fz.mant};
  end

  fp32_add u_ofs (.a(scaled), .b(offs), .y(y_lin));
  assign y_pos = (t_bits >= T5) ? ONE : y_lin;
  fp32_add u_neg (.a(ONE), .b({~y_pos[31], y_pos[30:0]}), .y(y_neg));
  assign sig = fz.sign ? y_neg : y_pos;

`ifdef PERCEPTRON_RELU_EN
  assign lin = fz.sign ? 32'd0 : z;
`else
  assign lin = z;
`endif

  assign act_val = activation_function ? sig : lin;

  always_ff @(posedge clk) begin
    if (rstn) begin
      counter   <= '0;
      acc       <= '0;
      sum_r     <= '0;
      sum_vld   <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      sum_vld   <= (counter == LAST);
      out_valid <= sum_vld;
      if (counter == LAST) begin
        counter <= '0;
        acc     <= '0;
        sum_r   <= acc_next;
      end else begin
        counter <= counter + 32'd1;
        acc     <= acc_next;
      end
      if (sum_vld) data_out <= act_val;
    end
  end

endmodule

// File: tb/tb_perceptron_sig_core.sv
// Table-driven bench with an expected-result queue popped on every out_valid pulse.
module tb_perceptron_sig_core;
  import perceptron_sig_core_pkg::*;

  localparam int N = 5;

`ifdef PERCEPTRON_RELU_EN
  localparam logic [31:0] NEG_LIN = 32'h0000_0000;
`else
  localparam logic [31:0] NEG_LIN = 32'hBF80_0000;
`endif

  typedef struct packed {
    logic [N-1:0][31:0] w;
    logic [N-1:0][31:0] x;
    logic [31:0]        b;
    logic               act;
    logic [31:0]        expv;
  } vec_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               activation_function = 1'b0;
  logic [31:0]        b = '0;
  logic [31:0]        w, x, counter, data_out;
  logic               out_valid;
  logic [N-1:0][31:0] w_mem = '0;
  logic [N-1:0][31:0] x_mem = '0;

  int          tests = 0, failed = 0;
  int          cyc = 0, pulses = 0, last_pulse = 0, gap = 0;
  logic [31:0] sb[$];
  vec_t        vt[$];

  always #5 clk = ~clk;

  always_comb begin
    w = '0;
    x = '0;
    for (int i = 0; i < N; i++) begin
      if (counter == 32'(i)) begin
        w = w_mem[i];
        x = x_mem[i];
      end
    end
  end

  perceptron_sig_core #(.COUNTER_END(N)) dut (
    .clk(clk), .rstn(rstn), .activation_function(activation_function),
    .b(b), .w(w), .x(x), .counter(counter), .data_out(data_out), .out_valid(out_valid)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (out_valid === 1'b1) begin
      gap        = cyc - last_pulse;
      last_pulse = cyc;
      pulses++;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pulse: got out_valid=1 data %h want no pulse", data_out);
      end else begin
        chk("pulse_data", data_out, sb.pop_front());
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] wa, input logic [31:0] xa,
                              input logic [31:0] bb, input logic ac, input logic [31:0] e);
    vec_t v;
    for (int i = 0; i < N; i++) begin
      v.w[i] = wa;
      v.x[i] = xa;
    end
    v.b    = bb;
    v.act  = ac;
    v.expv = e;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input string nm);
    for (int c = 0; c < 40 && pulses < target; c++) tick();
    tests++;
    if (pulses < target) begin
      failed++;
      $display("FAIL %s_timeout: got %0d pulses want %0d", nm, pulses, target);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int start;
    rstn  = 1'b1;
    w_mem = v.w;
    x_mem = v.x;
    b     = v.b;
    activation_function = v.act;
    tick();
    tick();
    sb.push_back(v.expv);
    sb.push_back(v.expv);
    start = pulses;
    rstn  = 1'b0;
    wait_pulses(start + 2, $sformatf("vec%0d", idx));
    chk($sformatf("vec%0d_period", idx), 32'(gap), 32'd5);
    tick();
    chk($sformatf("vec%0d_hold", idx), data_out, v.expv);
  endtask

  initial begin
    vec_t v;
    int   start;

    vt.push_back(mk(ONE, ONE, 32'h0, 1'b1, ONE));
    vt.push_back(mk(ONE, ONE, 32'h0, 1'b0, 32'h40A0_0000));
    vt.push_back(mk(32'h0, 32'h0, 32'h0, 1'b1, 32'h3F00_0000));
    v = mk(32'h0, ONE, 32'h0, 1'b1, 32'h3E80_0000); v.w[1] = 32'hBF80_0000; vt.push_back(v);
    v.act = 1'b0; v.expv = NEG_LIN; vt.push_back(v);
    vt.push_back(mk(32'h3F00_0000, ONE, 32'h0, 1'b0, 32'h4020_0000));
    vt.push_back(mk(32'h3F00_0000, ONE, 32'h0, 1'b1, 32'h3F6C_0000));
    vt.push_back(mk(32'h0, 32'h0, ONE, 1'b1, 32'h3F40_0000));
    vt.push_back(mk(32'h0, 32'h0, 32'hC040_0000, 1'b1, 32'h3D80_0000));
    v = mk(32'h4000_0000, 32'h0, HALF, 1'b0, 32'h4060_0000); v.x[0] = 32'h3FC0_0000; vt.push_back(v);
    v = mk(32'h0, 32'h0, 32'h0, 1'b0, 32'h7F80_0000);
    v.w[0] = 32'h7F00_0000; v.x[0] = 32'h4080_0000; vt.push_back(v);
    v.act = 1'b1; v.expv = ONE; vt.push_back(v);
    vt.push_back(mk(32'h0000_0001, ONE, 32'h0, 1'b0, 32'h0));
    vt.push_back(mk(32'hBF80_0000, ONE, 32'h0, 1'b1, 32'h0));
    vt.push_back(mk(32'h0, 32'h0, T2375, 1'b1, 32'h3F6B_0000));
    v = mk(32'h0, ONE, 32'h0, 1'b0, 32'h3F7F_FFFF);
    v.w[0] = ONE; v.w[1] = 32'hB300_0000; vt.push_back(v);
    vt.push_back(mk(ONE, ONE, 32'hC000_0000, 1'b1, 32'h3F70_0000));

    // Reset state.
    repeat (3) tick();
    chk("reset_counter", counter, 32'd0);
    chk("reset_data", data_out, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);

    foreach (vt[i]) run_vec(vt[i], i);

    // Abort a frame mid-way after a completed result.
    rstn = 1'b1; w_mem = mk(ONE, ONE, 0, 0, 0).w; x_mem = w_mem; b = '0;
    activation_function = 1'b0;
    tick(); tick();
    sb.push_back(32'h40A0_0000);
    start = pulses;
    rstn  = 1'b0;
    wait_pulses(start + 1, "abort_first");
    for (int c = 0; c < 10 && counter != 32'd2; c++) tick();
    chk("abort_at_2", counter, 32'd2);
    rstn = 1'b1;
    tick();
    chk("abort_counter", counter, 32'd0);
    chk("abort_data", data_out, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    w_mem = mk(32'h4000_0000, ONE, 0, 0, 0).w;
    sb.push_back(32'h4120_0000);
    start = pulses;
    rstn  = 1'b0;
    wait_pulses(start + 1, "abort_next");

    // Three-cycle reset, then check counter walk and first-pulse edge.
    rstn = 1'b1; w_mem = mk(ONE, ONE, 0, 0, 0).w; activation_function = 1'b1;
    repeat (3) tick();
    chk("seq_cnt0", counter, 32'd0);
    sb.push_back(ONE);
    rstn = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e <= 5) begin
        chk($sformatf("seq_cnt%0d", e), counter, 32'(e % N));
        chk($sformatf("seq_valid%0d", e), {31'd0, out_valid}, 32'd0);
      end else begin
        chk("seq_valid6", {31'd0, out_valid}, 32'd1);
      end
    end
    rstn = 1'b1;
    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
